// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO, ALU-style flags, busy/done handshake.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle '*' instead of shift-add.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [2:0]       flags_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, ovf_q, ovf_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [2:0]       flags_q, flags_d;
  logic             sgn, s1, s2, dz, ovf, ge;
  logic [WIDTH-1:0] m1, m2, step_q, quo, rem;
  logic [WIDTH:0]   sum, rr, step_acc;
  logic [2*WIDTH-1:0] prod_u, prod_s;
  assign sgn = ~op_i[0];
  assign s1  = sgn & in1_i[WIDTH-1];
  assign s2  = sgn & in2_i[WIDTH-1];
  assign m1  = s1 ? -in1_i : in1_i;
  assign m2  = s2 ? -in2_i : in2_i;
  assign dz  = op_i[1] & (in2_i == '0);
  assign ovf = (op_i == 2'b10) & (in1_i == MIN) & (in2_i == '1);
  // {acc,q} is the shift-add product register for multiply and the {remainder,dividend/quotient} pair for divide
  assign sum      = acc_q + {1'b0, (q_q[0] ? a_q : '0)};
  assign rr       = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign ge       = rr >= {1'b0, a_q};
  assign step_acc = op_q[1] ? (ge ? rr - {1'b0, a_q} : rr) : {1'b0, sum[WIDTH:1]};
  assign step_q   = op_q[1] ? {q_q[WIDTH-2:0], ge} : {sum[0], q_q[WIDTH-1:1]};
`ifdef MULDIV_FAST_MUL_EN
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, q_q};
`else
  assign prod_u = {step_acc[WIDTH-1:0], step_q};
`endif
  assign prod_s = neg_q ? -prod_u : prod_u;
  assign quo    = neg_q ? -step_q : step_q;
  assign rem    = rneg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    a_d     = a_q;
    q_d     = q_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          op_d    = op_i;
          neg_d   = s1 ^ s2;
          rneg_d  = s1;
          dz_d    = dz;
          ovf_d   = ovf;
          acc_d   = '0;
          a_d     = op_i[1] ? m2 : m1;
          q_d     = dz ? in1_i : (op_i[1] ? m1 : m2);
          cnt_d   = (dz | (FAST_MUL & ~op_i[1])) ? CW'(1) : CW'(WIDTH);
        end else begin
          hi_d = hi_we_i ? wdata_i : hi_q;
          lo_d = lo_we_i ? wdata_i : lo_q;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          acc_d = dz_q ? acc_q : step_acc;
          q_d   = dz_q ? q_q : step_q;
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            if (dz_q) begin
              hi_d    = q_q;
              lo_d    = '1;
              flags_d = 3'b011;
            end else if (op_q[1]) begin
              hi_d    = rem;
              lo_d    = quo;
              flags_d = {quo == '0, ~op_q[0] & quo[WIDTH-1], ovf_q};
            end else begin
              hi_d    = prod_s[2*WIDTH-1:WIDTH];
              lo_d    = prod_s[WIDTH-1:0];
              flags_d = {prod_s == '0, ~op_q[0] & prod_s[2*WIDTH-1], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flags_q <= flags_d;
    end
  end
  assign busy_o  = state_q == RUN;
  assign done_o  = state_q == DONE;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign flags_o = flags_q;
endmodule
